// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration-bus arbiter.
// Defines the arbiter FSM states and the controller word format.
package i2c_cfg_pkg;

    localparam int         I2C_WORD_W      = 24;
    localparam logic [7:0] HDMI_SLAVE_ADDR = 8'h72;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_START,
        WAIT_END,
        GAP,
        FINISH
    } arb_state_e;

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin pick: the first active request at or after the
// pointer wins, with the search wrapping from N_REQ-1 back to 0.
module i2c_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);

    int   cand;
    logic found;

    always_comb begin
        // NOTE: every output gets a default before the loop, so no latch is inferred.
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one 24-bit I2C write controller between N_REQ configuration
// requesters: round-robin grant, GO/END handshake, NACK retry and timeout.
module i2c_bus_arbiter
    import i2c_cfg_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int MAX_RETRY   = 3,
    parameter int GAP_CYC     = 1000,
    parameter int TIMEOUT_CYC = 1 << 20
) (
    input  logic                          iCLK,
    input  logic                          iRST_N,
    input  logic [N_REQ-1:0]              iREQ,
    input  logic [I2C_WORD_W*N_REQ-1:0]   iDATA,
    output logic [N_REQ-1:0]              oGNT,
    output logic [N_REQ-1:0]              oDONE,
    output logic [N_REQ-1:0]              oERR,
    output logic                          oBUSY,
    output logic [I2C_WORD_W-1:0]         oI2C_DATA,
    output logic                          oI2C_GO,
    input  logic                          iI2C_END,
    input  logic                          iI2C_ACK
);

    localparam int PTR_W   = $clog2(N_REQ);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int GAP_W   = $clog2(GAP_CYC + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(N_REQ - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYC - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

    arb_state_e              state_q, state_d;
    logic [N_REQ-1:0]        gnt_q, gnt_d;
    logic [PTR_W-1:0]        idx_q, idx_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [I2C_WORD_W-1:0]   data_q, data_d;
    logic [RETRY_W-1:0]      retry_q, retry_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    err_q, err_d;

    logic                    end_meta_q, end_sync_q;
    logic                    ack_meta_q, ack_sync_q;

    logic [N_REQ-1:0]        arb_gnt;
    logic [PTR_W-1:0]        arb_idx;
    logic                    arb_valid;
    logic                    tmo_hit;
    logic [N_REQ-1:0]        done_vec;

    i2c_rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req_i   (iREQ),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign tmo_hit = (tmo_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        retry_d = retry_q;
        gap_d   = gap_q;
        tmo_d   = tmo_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d   = arb_gnt;
                    idx_d   = arb_idx;
                    data_d  = iDATA[int'(arb_idx)*I2C_WORD_W +: I2C_WORD_W];
                    retry_d = '0;
                    err_d   = 1'b0;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                tmo_d   = '0;
                state_d = WAIT_START;
            end

            // Timeout is checked first: a hung controller aborts without retry.
            WAIT_START: begin
                if (tmo_hit) begin
                    err_d   = 1'b1;
                    gnt_d   = '0;
                    state_d = FINISH;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (!end_sync_q) begin
                        state_d = WAIT_END;
                    end
                end
            end

            WAIT_END: begin
                if (tmo_hit) begin
                    err_d   = 1'b1;
                    gnt_d   = '0;
                    state_d = FINISH;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (end_sync_q) begin
                        if (!ack_sync_q) begin
                            err_d   = 1'b0;
                            gnt_d   = '0;
                            state_d = FINISH;
                        end else if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + RETRY_W'(1);
                            gap_d   = '0;
                            state_d = GAP;
                        end else begin
                            err_d   = 1'b1;
                            gnt_d   = '0;
                            state_d = FINISH;
                        end
                    end
                end
            end

            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = LOAD;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            FINISH: begin
                ptr_d   = (idx_q == PTR_LAST) ? '0 : idx_q + PTR_W'(1);
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            idx_q      <= '0;
            ptr_q      <= '0;
            data_q     <= '0;
            retry_q    <= '0;
            gap_q      <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            end_meta_q <= 1'b0;
            end_sync_q <= 1'b0;
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            data_q     <= data_d;
            retry_q    <= retry_d;
            gap_q      <= gap_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            end_meta_q <= iI2C_END;
            end_sync_q <= end_meta_q;
            ack_meta_q <= iI2C_ACK;
            ack_sync_q <= ack_meta_q;
        end
    end

    // Outputs decode straight from state so reset drops GO/GNT/BUSY at once.
    always_comb begin
        done_vec = '0;
        if (state_q == FINISH) begin
            done_vec[idx_q] = 1'b1;
        end
    end

    assign oGNT      = gnt_q;
    assign oDONE     = done_vec;
    assign oERR      = err_q ? done_vec : '0;
    assign oBUSY     = (state_q != IDLE);
    assign oI2C_GO   = (state_q == LOAD) || (state_q == WAIT_START) || (state_q == WAIT_END);
    assign oI2C_DATA = data_q;

endmodule
